// File: rtl/l1_cache_controller.sv
// ---------------------------------------------------------------------------------------------
// l1_cache_controller
//   L1 data cache between a CPU load/store port and main memory.
//   2-way set associative, 64 sets, 64-byte lines, write-through, no-write-allocate,
//   1-bit LRU per set. Hits complete in one cycle. A read miss refills a whole 512-bit line
//   with one memory burst. Every store is forwarded to memory as a single-word write.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   phy_addr             CPU byte address (tag [31:12], index [11:6], word [5:2])
//   data_from_cpu        CPU store data
//   read_mem, write_mem  load / store request (load wins if both are high)
//   data_to_cpu          registered load data
//   hit_miss             registered hit flag of the last accepted request
//   ready_stall          1 while a memory transaction is outstanding
//   main_mem_addr        memory address, held until main_mem_ready
//   main_mem_data_out    write-through data, held until main_mem_ready
//   main_mem_read_req    one-cycle line-read request pulse
//   main_mem_write_req   one-cycle word-write request pulse
//   main_mem_data_in     refill line, word i at bits [32*i+31:32*i]
//   main_mem_ready       one-cycle completion pulse
// ---------------------------------------------------------------------------------------------
module l1_cache_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  phy_addr,
    input  logic [31:0]  data_from_cpu,
    input  logic         read_mem,
    input  logic         write_mem,
    output logic [31:0]  data_to_cpu,
    output logic         hit_miss,
    output logic         ready_stall,
    output logic [31:0]  main_mem_addr,
    output logic [31:0]  main_mem_data_out,
    output logic         main_mem_read_req,
    output logic         main_mem_write_req,
    input  logic [511:0] main_mem_data_in,
    input  logic         main_mem_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait
    } state_e;

    state_e state_q, state_d;

    // Word address of the request being refilled
    logic [31:2] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic        hit_q, hit_d;
    logic        stall_q, stall_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mdata_q, mdata_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;

    // Tag / valid / LRU store and line data array
    logic [1:0][63:0] valid_q, valid_d;
    logic [63:0]      lru_q, lru_d;
    logic [19:0]      tag_q  [2][64];
    logic [511:0]     line_q [2][64];

    // Lookup of the incoming request
    logic [5:0]   req_idx;
    logic [19:0]  req_tag;
    logic [3:0]   req_word;
    logic         hit0, hit1, req_hit, hit_way;
    logic [511:0] hit_line;
    logic [31:0]  hit_word;

    // Refill side, indexed by the latched address
    logic [5:0]  fill_idx;
    logic [3:0]  fill_word;
    logic        victim;

    // Array write strobes
    logic fill_en;
    logic store_en;

    assign req_idx  = phy_addr[11:6];
    assign req_tag  = phy_addr[31:12];
    assign req_word = phy_addr[5:2];

    assign hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign req_hit  = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = hit_way ? line_q[1][req_idx] : line_q[0][req_idx];
    assign hit_word = hit_line[{req_word, 5'b0} +: 32];

    assign fill_idx  = addr_q[11:6];
    assign fill_word = addr_q[5:2];

    // Invalid ways are filled first (way0 preferred); otherwise the LRU bit names the victim.
    always_comb begin
        if (!valid_q[0][fill_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][fill_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[fill_idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        hit_d    = hit_q;
        stall_d  = stall_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        valid_d  = valid_q;
        lru_d    = lru_q;
        fill_en  = 1'b0;
        store_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read_mem) begin
                    addr_d = phy_addr[31:2];
                    hit_d  = req_hit;
                    if (req_hit) begin
                        dout_d         = hit_word;
                        lru_d[req_idx] = ~hit_way;
                    end else begin
                        stall_d  = 1'b1;
                        maddr_d  = {phy_addr[31:6], 6'b0};
                        rd_req_d = 1'b1;
                        state_d  = StRdWait;
                    end
                end else if (write_mem) begin
                    addr_d = phy_addr[31:2];
                    hit_d  = req_hit;
                    if (req_hit) begin
                        store_en       = 1'b1;
                        lru_d[req_idx] = ~hit_way;
                    end
                    stall_d  = 1'b1;
                    maddr_d  = phy_addr;
                    mdata_d  = data_from_cpu;
                    wr_req_d = 1'b1;
                    state_d  = StWrWait;
                end
            end
            StRdWait: begin
                if (main_mem_ready) begin
                    fill_en                   = 1'b1;
                    valid_d[victim][fill_idx] = 1'b1;
                    lru_d[fill_idx]           = ~victim;
                    dout_d   = main_mem_data_in[{fill_word, 5'b0} +: 32];
                    stall_d  = 1'b0;
                    state_d  = StIdle;
                end
            end
            StWrWait: begin
                if (main_mem_ready) begin
                    stall_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            dout_q   <= '0;
            hit_q    <= 1'b0;
            stall_q  <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            valid_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            hit_q    <= hit_d;
            stall_q  <= stall_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            valid_q  <= valid_d;
            lru_q    <= lru_d;
        end
    end

    // Tags and line data need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim][fill_idx]  <= addr_q[31:12];
            line_q[victim][fill_idx] <= main_mem_data_in;
        end
        if (store_en) begin
            line_q[hit_way][req_idx][{req_word, 5'b0} +: 32] <= data_from_cpu;
        end
    end

    assign data_to_cpu        = dout_q;
    assign hit_miss           = hit_q;
    assign ready_stall        = stall_q;
    assign main_mem_addr      = maddr_q;
    assign main_mem_data_out  = mdata_q;
    assign main_mem_read_req  = rd_req_q;
    assign main_mem_write_req = wr_req_q;

endmodule

// File: tb/tb_l1_cache_controller.sv
// ---------------------------------------------------------------------------------------------
// tb_l1_cache_controller
//   Self-checking bench: directed scenarios followed by random loads/stores. Expected values
//   come from a word-addressed memory model (all words start at 1) and a per-set recency list
//   of resident tags (at most two, most recent first).
// ---------------------------------------------------------------------------------------------
module tb_l1_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  phy_addr;
    logic [31:0]  data_from_cpu;
    logic         read_mem;
    logic         write_mem;
    logic [31:0]  data_to_cpu;
    logic         hit_miss;
    logic         ready_stall;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;

    l1_cache_controller dut (
        .clk                (clk),
        .rst                (rst),
        .phy_addr           (phy_addr),
        .data_from_cpu      (data_from_cpu),
        .read_mem           (read_mem),
        .write_mem          (write_mem),
        .data_to_cpu        (data_to_cpu),
        .hit_miss           (hit_miss),
        .ready_stall        (ready_stall),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model keyed by word address
    logic [31:0] mem_q [int unsigned];
    // Resident tags per set, most recently used first
    int unsigned set_q [64][$];
    logic [31:0] exp_dout;
    logic        exp_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k = int'(a[31:2]);
        return mem_q.exists(k) ? mem_q[k] : 32'h0000_0001;
    endfunction

    // Returns hit; reads allocate (evicting the least recent of two), writes never allocate.
    function automatic bit model_access(input bit is_read, input logic [31:0] a);
        int unsigned idx = int'(a[11:6]);
        int unsigned tg  = int'(a[31:12]);
        int pos = -1;
        for (int i = 0; i < set_q[idx].size(); i++) begin
            if (set_q[idx][i] == tg) pos = i;
        end
        if (pos >= 0) begin
            set_q[idx].delete(pos);
            set_q[idx].push_front(tg);
            return 1'b1;
        end
        if (is_read) begin
            set_q[idx].push_front(tg);
            if (set_q[idx].size() > 2) void'(set_q[idx].pop_back());
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) set_q[i].delete();
        exp_dout = '0;
        exp_hit  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " data_to_cpu"}, data_to_cpu, 32'h0);
        check_eq({tag, " hit_miss"}, {31'h0, hit_miss}, 32'h0);
        check_eq({tag, " ready_stall"}, {31'h0, ready_stall}, 32'h0);
        check_eq({tag, " mem_addr"}, main_mem_addr, 32'h0);
        check_eq({tag, " mem_data_out"}, main_mem_data_out, 32'h0);
        check_eq({tag, " read_req"}, {31'h0, main_mem_read_req}, 32'h0);
        check_eq({tag, " write_req"}, {31'h0, main_mem_write_req}, 32'h0);
    endtask

    // Idle cycles must leave every output untouched.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle stall", {31'h0, ready_stall}, 32'h0);
            check_eq("idle reqs", {30'h0, main_mem_read_req, main_mem_write_req}, 32'h0);
            check_eq("idle hit_miss", {31'h0, hit_miss}, {31'h0, exp_hit});
            check_eq("idle data", data_to_cpu, exp_dout);
        end
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data);
        bit          is_read = rd;
        bit          hit;
        logic [511:0] line;
        int          wait_n;
        hit = model_access(is_read, addr);
        exp_hit = hit;
        @(negedge clk);
        phy_addr      = addr;
        data_from_cpu = data;
        read_mem      = rd;
        write_mem     = wr;
        @(posedge clk);
        #1;
        read_mem  = 1'b0;
        write_mem = 1'b0;
        check_eq("hit_miss", {31'h0, hit_miss}, {31'h0, hit});
        if (is_read && hit) begin
            exp_dout = mem_rd(addr);
            check_eq("rd hit data", data_to_cpu, exp_dout);
            check_eq("rd hit stall", {31'h0, ready_stall}, 32'h0);
            check_eq("rd hit reqs", {30'h0, main_mem_read_req, main_mem_write_req}, 32'h0);
            return;
        end
        check_eq("stall set", {31'h0, ready_stall}, 32'h1);
        if (is_read) begin
            check_eq("read_req", {30'h0, main_mem_read_req, main_mem_write_req}, 32'h2);
            check_eq("read addr", main_mem_addr, {addr[31:6], 6'b0});
        end else begin
            check_eq("write_req", {30'h0, main_mem_read_req, main_mem_write_req}, 32'h1);
            check_eq("write addr", main_mem_addr, addr);
            check_eq("write data", main_mem_data_out, data);
        end
        // Memory latency; throw ignored requests at the stalled cache.
        wait_n = int'($urandom_range(3, 6));
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            phy_addr      = $urandom;
            data_from_cpu = $urandom;
            read_mem      = 1'($urandom);
            write_mem     = 1'($urandom);
            @(posedge clk);
            #1;
            read_mem  = 1'b0;
            write_mem = 1'b0;
            check_eq("wait stall", {31'h0, ready_stall}, 32'h1);
            check_eq("wait reqs", {30'h0, main_mem_read_req, main_mem_write_req}, 32'h0);
        end
        @(negedge clk);
        if (is_read) begin
            for (int i = 0; i < 16; i++) begin
                line[i*32 +: 32] = mem_rd({addr[31:6], 6'(i * 4)});
            end
            main_mem_data_in = line;
        end else begin
            main_mem_data_in = {16{32'hBADC0FFE}};
            mem_q[int'(addr[31:2])] = data;
        end
        main_mem_ready = 1'b1;
        @(posedge clk);
        #1;
        main_mem_ready = 1'b0;
        if (is_read) exp_dout = mem_rd(addr);
        check_eq("done stall", {31'h0, ready_stall}, 32'h0);
        check_eq("done data", data_to_cpu, exp_dout);
        check_eq("done hit_miss", {31'h0, hit_miss}, {31'h0, hit});
    endtask

    // Reset asserted while a refill is outstanding.
    task automatic reset_mid_read(input logic [31:0] addr);
        @(negedge clk);
        phy_addr = addr;
        read_mem = 1'b1;
        @(posedge clk);
        #1;
        read_mem = 1'b0;
        check_eq("rst-mid read_req", {31'h0, main_mem_read_req}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst-mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_cycles(2);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst              = 1'b1;
        phy_addr         = '0;
        data_from_cpu    = '0;
        read_mem         = 1'b0;
        write_mem        = 1'b0;
        main_mem_data_in = '0;
        main_mem_ready   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Cold miss then hit in the same line
        do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        // Write hit then read back
        do_op(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        // Write miss does not allocate
        do_op(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678);
        do_op(1'b1, 1'b0, 32'h0000_2000, 32'h0);
        // LRU replacement in set 1
        do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_1040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_2040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_op(1'b1, 1'b0, 32'h0000_1040, 32'h0);
        // Simultaneous read and write: read wins
        do_op(1'b1, 1'b1, 32'h0000_3004, 32'hFFFF_0000);
        idle_cycles(1);

        // Reset during RD_WAIT, then the same address misses again
        reset_mid_read(32'h0000_3080);
        do_op(1'b1, 1'b0, 32'h0000_3080, 32'h0);

        // Random traffic over a few conflicting tags and sets
        for (int n = 0; n < 200; n++) begin
            a = {20'($urandom_range(0, 3)), 6'($urandom_range(0, 2)),
                 4'($urandom), 2'($urandom)};
            if ($urandom_range(0, 3) == 0) a[11:6] = 6'd63;
            op = int'($urandom_range(0, 9));
            if (op < 5)      do_op(1'b1, 1'b0, a, 32'h0);
            else if (op < 8) do_op(1'b0, 1'b1, a, $urandom);
            else             do_op(1'b1, 1'b1, a, $urandom);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
